// File: rtl/if_fetch_if.sv
// Byte-wide read bus between the instruction-fetch stage and the memory controller.
// The fetch stage is the master: it holds req/addr and gets one rdata byte per rvalid pulse.
interface if_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic [7:0]  rdata;
    logic        rvalid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four little-endian byte reads.
// Optional IF_MISALIGN_TRAP_EN: a redirect to an unaligned target raises excp_IF_o instead of fetching.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        dclk,
    input  logic        rst_n,
    input  logic [1:0]  stl_STALLER_i,
    input  logic        br_EX_i,
    input  logic [31:0] br_addr_EX_i,
    if_fetch_if.master  mem,
    output logic        stlreq_STALLER_o,
    output logic [31:0] inst_IF_o,
    output logic [31:0] pc_IF_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        excp_IF_o
`endif
);

    // Only None lets a finished instruction advance; Stall, Bubble and the unused code all hold.
    localparam logic [1:0] STL_NONE = 2'b00;

    typedef enum logic {
        FETCH,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [1:0]  cnt;
    logic        flush_q;
    logic [31:0] tgt_q;
    logic [7:0]  byte0_q;
    logic [7:0]  byte1_q;
    logic [7:0]  byte2_q;
    logic        req_q;
    logic [31:0] addr_q;

    logic        outstanding;
    logic        take_br;
    logic        redirect;
    logic [31:0] redir_pc;

    assign mem.req  = req_q;
    assign mem.addr = addr_q;

    // A branch can act at once unless a byte request is still waiting for its rvalid;
    // in that case it is parked in tgt_q and applied when the transaction completes.
    always_comb begin
        outstanding = 1'b0;
        take_br     = 1'b0;
        redirect    = 1'b0;
        redir_pc    = tgt_q;
        outstanding = (state == FETCH) && req_q;
        take_br     = br_EX_i && !(outstanding && !mem.rvalid);
        redirect    = take_br || (outstanding && mem.rvalid && flush_q);
        if (take_br) begin
            redir_pc = br_addr_EX_i;
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FETCH;
            pc_q             <= RESET_PC;
            cnt              <= 2'd0;
            flush_q          <= 1'b0;
            tgt_q            <= 32'd0;
            byte0_q          <= 8'd0;
            byte1_q          <= 8'd0;
            byte2_q          <= 8'd0;
            req_q            <= 1'b0;
            addr_q           <= 32'd0;
            inst_IF_o        <= 32'd0;
            pc_IF_o          <= 32'd0;
            stlreq_STALLER_o <= 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            excp_IF_o        <= 1'b0;
`endif
        end else if (redirect) begin
            pc_q      <= redir_pc;
            cnt       <= 2'd0;
            flush_q   <= 1'b0;
            req_q     <= 1'b0;
            inst_IF_o <= 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
            if (redir_pc[1:0] != 2'b00) begin
                state            <= DONE;
                pc_IF_o          <= redir_pc;
                stlreq_STALLER_o <= 1'b0;
                excp_IF_o        <= 1'b1;
            end else begin
                state            <= FETCH;
                stlreq_STALLER_o <= 1'b1;
                excp_IF_o        <= 1'b0;
            end
`else
            state            <= FETCH;
            stlreq_STALLER_o <= 1'b1;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= pc_q + {30'd0, cnt};
                    end else if (mem.rvalid) begin
                        req_q <= 1'b0;
                        cnt   <= cnt + 2'd1;
                        case (cnt)
                            2'd0: byte0_q <= mem.rdata;
                            2'd1: byte1_q <= mem.rdata;
                            2'd2: byte2_q <= mem.rdata;
                            default: begin
                                state            <= DONE;
                                inst_IF_o        <= {mem.rdata, byte2_q, byte1_q, byte0_q};
                                pc_IF_o          <= pc_q;
                                stlreq_STALLER_o <= 1'b0;
                            end
                        endcase
                    end else if (br_EX_i) begin
                        flush_q <= 1'b1;
                        tgt_q   <= br_addr_EX_i;
                    end
                end
                DONE: begin
`ifdef IF_MISALIGN_TRAP_EN
                    if (stl_STALLER_i == STL_NONE && !excp_IF_o) begin
`else
                    if (stl_STALLER_i == STL_NONE) begin
`endif
                        pc_q             <= pc_q + 32'd4;
                        cnt              <= 2'd0;
                        state            <= FETCH;
                        inst_IF_o        <= 32'd0;
                        stlreq_STALLER_o <= 1'b1;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
